// File: rtl/leading_zero_sequencer.sv
// Multi-cycle leading zero counter: scans CHUNK bits per cycle, MSB first.
// Option: define LZS_EARLY_EXIT_EN to stop on the first nonzero chunk.

module LeadingZeroCounter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  logic w_hit;

  // Priority scan from MSB; all-zero input yields WIDTH
  always_comb begin
    o_count = CW'(WIDTH);
    w_hit   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_hit && i_data[i]) begin
        o_count = CW'(WIDTH - 1 - i);
        w_hit   = 1'b1;
      end
    end
  end

endmodule

module leading_zero_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [WIDTH-1:0]           operand,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [$clog2(WIDTH):0]     result
);

  localparam int CHUNKS = WIDTH / CHUNK;
  localparam int RW     = $clog2(WIDTH) + 1;
  localparam int CW     = $clog2(CHUNK) + 1;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [RW-1:0]    r_acc;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  logic [RW-1:0]    r_result;

  logic [CW-1:0]    w_c;
  logic [RW-1:0]    w_sum;
  logic             w_hit;
  logic             w_last;
  logic             w_term;
  logic             w_accept;

  LeadingZeroCounter #(
    .WIDTH (CHUNK),
    .CW    (CW)
  ) u_lzc (
    .i_data  (r_shift[WIDTH-1:WIDTH-CHUNK]),
    .o_count (w_c)
  );

  assign w_hit  = (w_c < CW'(CHUNK));
  assign w_last = (r_idx == IW'(CHUNKS - 1));
  // Once a set bit was seen, later chunk counts are discarded
  assign w_sum  = r_found ? r_acc : (r_acc + RW'(w_c));

`ifdef LZS_EARLY_EXIT_EN
  assign w_term = w_hit || w_last;
`else
  assign w_term = w_last;
`endif

  assign w_accept = inValid && inReady;
  assign result   = r_result;

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next   = r_state;
    inReady  = 1'b0;
    outValid = 1'b0;
    unique case (r_state)
      IDLE: begin
        inReady = resetN;
        if (inValid && resetN) w_next = SCAN;
      end
      SCAN: begin
        if (w_term) w_next = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load on accept, accumulate per chunk, capture result
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_shift  <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_found  <= 1'b0;
      r_result <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_shift <= operand;
        r_acc   <= '0;
        r_idx   <= '0;
        r_found <= 1'b0;
      end
    end else if (r_state == SCAN) begin
      r_acc   <= w_sum;
      r_found <= r_found || w_hit;
      r_shift <= r_shift << CHUNK;
      r_idx   <= r_idx + IW'(1);
      if (w_term) r_result <= w_sum;
    end
  end

endmodule
